// File: rtl/datapath_pkg.sv
// Shared definitions for the multi-cycle RV32I datapath: opcodes, ALU
// operation codes, FSM states and the decoded control set.
package datapath_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the multi-cycle datapath. The MUL operation is only
// built when DATAPATH_MUL_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Select the result for the requested operation; shifts use b[4:0]
  always_comb begin
    y = '0;
    case (alu_op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
`ifdef DATAPATH_MUL_EN
      ALU_MUL:  y = a * b;
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I datapath (R/I ALU, LW, SW): FSM, decoder, register file
// and word-addressed data memory. Define DATAPATH_MUL_EN to accept MUL.
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int RW = $clog2(NREGS);

  state_t      state_reg, state_next;
  logic [31:0] ir_reg;
  ctrl_t       ctrl_dec, ctrl_reg;
  logic        ill_dec, ill_reg, uses_rs2, uses_rd, misaligned, mem_op, rd_written;
  logic [31:0] imm_dec, rs1_val, rs2_val, alu_y, wb_data;
  logic [31:0] op_a_reg, op_b_reg, store_reg, res_reg, load_reg;
  logic [AW-1:0] mem_idx;
  logic [31:0] regs [NREGS];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  assign opcode = ir_reg[6:0];
  assign rd     = ir_reg[11:7];
  assign funct3 = ir_reg[14:12];
  assign rs1    = ir_reg[19:15];
  assign rs2    = ir_reg[24:20];
  assign funct7 = ir_reg[31:25];

  assign rs1_val   = (rs1 != 5'd0 && reg_ok(rs1)) ? regs[rs1[RW-1:0]] : '0;
  assign rs2_val   = (rs2 != 5'd0 && reg_ok(rs2)) ? regs[rs2[RW-1:0]] : '0;
  assign dbg_rdata = (dbg_raddr != 5'd0 && reg_ok(dbg_raddr)) ? regs[dbg_raddr[RW-1:0]] : '0;

  // Decode the latched instruction into control set, immediate and legality
  always_comb begin
    ctrl_dec = '0;
    imm_dec  = sext12(ir_reg[31:20]);
    ill_dec  = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_dec.reg_write = 1'b1;
        uses_rs2 = 1'b1;
        uses_rd  = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: ctrl_dec.alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: ctrl_dec.alu_op = ALU_SUB;
          {7'b0000000, 3'b001}: ctrl_dec.alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: ctrl_dec.alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: ctrl_dec.alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: ctrl_dec.alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: ctrl_dec.alu_op = ALU_SRL;
          {7'b0100000, 3'b101}: ctrl_dec.alu_op = ALU_SRA;
          {7'b0000000, 3'b110}: ctrl_dec.alu_op = ALU_OR;
          {7'b0000000, 3'b111}: ctrl_dec.alu_op = ALU_AND;
`ifdef DATAPATH_MUL_EN
          {7'b0000001, 3'b000}: ctrl_dec.alu_op = ALU_MUL;
`endif
          default: ill_dec = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        uses_rd = 1'b1;
        case (funct3)
          3'b000: ctrl_dec.alu_op = ALU_ADD;
          3'b010: ctrl_dec.alu_op = ALU_SLT;
          3'b011: ctrl_dec.alu_op = ALU_SLTU;
          3'b100: ctrl_dec.alu_op = ALU_XOR;
          3'b110: ctrl_dec.alu_op = ALU_OR;
          3'b111: ctrl_dec.alu_op = ALU_AND;
          3'b001: begin
            ctrl_dec.alu_op = ALU_SLL;
            ill_dec = (funct7 != 7'b0000000);
          end
          default: begin
            // funct3 = 101: SRLI or SRAI selected by the upper immediate bits
            ctrl_dec.alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            ill_dec = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.alu_op     = ALU_ADD;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        uses_rd = 1'b1;
        ill_dec = (funct3 != 3'b010);
      end
      OP_STORE: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
        ctrl_dec.mem_write = 1'b1;
        uses_rs2 = 1'b1;
        imm_dec  = sext12({ir_reg[31:25], ir_reg[11:7]});
        ill_dec  = (funct3 != 3'b010);
      end
      default: ill_dec = 1'b1;
    endcase
    if (!reg_ok(rs1) || (uses_rs2 && !reg_ok(rs2)) || (uses_rd && !reg_ok(rd)))
      ill_dec = 1'b1;
  end

  datapath_alu u_alu (
    .alu_op (ctrl_reg.alu_op),
    .a      (op_a_reg),
    .b      (op_b_reg),
    .y      (alu_y)
  );

  assign mem_op     = ctrl_reg.mem_read | ctrl_reg.mem_write;
  assign misaligned = mem_op && (alu_y[1:0] != 2'b00);
  assign mem_idx    = res_reg[AW+1:2];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state sequencing; illegal instructions skip MEM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (instr_valid) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (ill_reg || misaligned || !mem_op) ? S_WB : S_MEM;
      S_MEM:    state_next = S_WB;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pipeline-free datapath registers advanced by the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_reg    <= '0;
      ctrl_reg  <= '0;
      ill_reg   <= 1'b0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      store_reg <= '0;
      res_reg   <= '0;
      load_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (instr_valid) ir_reg <= instruction;
        S_DECODE: begin
          ctrl_reg  <= ctrl_dec;
          ill_reg   <= ill_dec;
          op_a_reg  <= rs1_val;
          op_b_reg  <= ctrl_dec.alu_src ? imm_dec : rs2_val;
          store_reg <= rs2_val;
        end
        S_EXEC: begin
          res_reg <= alu_y;
          if (misaligned) ill_reg <= 1'b1;
        end
        S_MEM: if (ctrl_reg.mem_read) load_reg <= dmem[mem_idx];
        default: ;
      endcase
    end
  end

  // Data memory: cleared on reset, written by SW in MEM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (state_reg == S_MEM && ctrl_reg.mem_write) begin
      dmem[mem_idx] <= store_reg;
    end
  end

  assign wb_data    = ctrl_reg.mem_to_reg ? load_reg : res_reg;
  assign rd_written = retire_valid && ctrl_reg.reg_write && (rd != 5'd0);

  // Register file: cleared on reset, written at the edge that ends WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rd_written) begin
      regs[rd[RW-1:0]] <= wb_data;
    end
  end

  assign instr_ready  = (state_reg == S_IDLE);
  assign retire_valid = (state_reg == S_WB) && !ill_reg;
  assign illegal      = (state_reg == S_WB) && ill_reg;
  assign retire_rd    = rd_written ? rd : 5'd0;
  assign retire_data  = rd_written ? wb_data :
                        (retire_valid && ctrl_reg.mem_write) ? res_reg : 32'd0;

endmodule
